piso_tx_sched: RTL and testbench
================================

Name: piso_tx_sched

Overview:
- Serial-transmit scheduler that shares one parallel-in/serial-out shift path between two parallel requesters.
- Arbitrates between the requesters round-robin and captures the granted word.
- Sequences load, then LSB-first shift-out at a programmable bit period, framed with valid, start and end markers.
- Sits between word producers and the serial line, replacing free-running mode control of the shift register.

Parameters:
- WIDTH, 4, bits per word; legal range 2 or more.
- DIV, 1, clock cycles per serial bit; legal range 1 or more.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 has a word pending.
- data0  in  WIDTH  requester 0 word; must be stable while req0 is high.
- gnt0  out  1  combinational one-cycle grant; data0 is captured on the edge ending this cycle.
- req1  in  1  requester 1 has a word pending.
- data1  in  WIDTH  requester 1 word.
- gnt1  out  1  grant to requester 1, same rules as gnt0.
- busy  out  1  registered; high in SHIFT and GAP states.
- so  out  1  registered serial data.
- so_valid  out  1  registered; high while so carries a frame bit.
- sof  out  1  registered; high during every cycle of bit 0.
- eof  out  1  registered; high during every cycle of bit WIDTH-1.
- src  out  1  registered; index of the requester owning the current frame.

Behaviour:
- Reset (async):
  - state=IDLE; shift register, bit counter and divider counter cleared.
  - Round-robin pointer=0 (requester 0 preferred).
  - All registered outputs 0.
  - Reset mid-frame aborts the frame immediately. No partial eof. The pending requester is not granted until it is seen again in IDLE.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - gnt0/gnt1 are decoded only in IDLE; they are never both high.
  - Only one req high: grant it.
  - Both high: grant the requester named by the pointer.
  - On the grant edge:
    - shreg<=granted data; src<=index.
    - so<=data[0]; so_valid<=1; sof<=1.
    - eof<=1 only if WIDTH-1==0, which is never the case given WIDTH>=2.
    - Bit counter<=0; divider<=0.
    - Pointer<=other requester; state<=SHIFT.
  - No req: stay in IDLE, outputs 0.
- SHIFT:
  - Each bit is held exactly DIV cycles. The divider counts 0..DIV-1.
  - At divider==DIV-1 with bit counter<WIDTH-1:
    - shreg shifts right.
    - so<=next bit; bit counter++; divider<=0.
    - sof<=0; eof<=(new count==WIDTH-1).
  - At divider==DIV-1 with bit counter==WIDTH-1:
    - so<=0; so_valid<=0; eof<=0.
    - state<=GAP.
  - Requests are ignored in SHIFT (gnt low). Requesters hold req and data.
- GAP:
  - Exactly one idle cycle with so=0 and so_valid=0. busy stays high.
  - Next state is IDLE. busy<=0 on that edge.
- Latency and throughput:
  - Grant in cycle t, first bit in cycle t+1, last bit in cycle t+WIDTH*DIV, GAP in cycle t+WIDTH*DIV+1.
  - Next grant is possible in cycle t+WIDTH*DIV+2.
- Fairness:
  - With both requesters continuously requesting, grants alternate 0,1,0,1.
  - A single continuous requester gets back-to-back frames separated by GAP plus one IDLE cycle.
- A requester may drop req before it is granted, with no side effects.
- so is always 0 whenever so_valid is 0.

Test Plan:
- Single word, WIDTH=4, DIV=1: req0=1, data0=4'b1011 in IDLE at cycle t.
  - gnt0=1 at t.
  - so=1,1,0,1 at t+1..t+4, with so_valid high over the same cycles.
  - sof only at t+1; eof only at t+4.
  - so_valid=0 at t+5; next gnt possible at t+6.
- Contention: req0 and req1 both held from reset.
  - Grant order is 0,1,0,1.
  - src matches each grant; no overlap of gnt0 and gnt1.
  - Each frame carries the correct word.
- Bit period, DIV=3, data1=4'b0110:
  - Each bit is held 3 cycles: 0,0,0,1,1,1,1,1,1,0,0,0.
  - sof spans the first 3 cycles; eof spans the last 3 cycles.
- Reset mid-frame: assert reset during bit 2.
  - so, so_valid, eof and busy go to 0 asynchronously.
  - After release with req1 high only, gnt1 is issued on the first IDLE cycle.
- Withdrawn request: req0 pulses high for one cycle while SHIFT is busy with a frame for requester 1.
  - No gnt0 is issued and no frame for requester 0 follows.
- Pointer: req1 alone is granted, then both requesters request.
  - The next grant goes to requester 0.

Source files
------------

// File: rtl/piso_tx_sched.sv
// Two-requester round-robin scheduler driving one parallel-in/serial-out path.
// A granted word goes out LSB-first, one bit per DIV clocks, then one GAP cycle.
module piso_tx_sched #(
   parameter int WIDTH = 4,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt1,
   output logic             busy,
   output logic             so,
   output logic             so_valid,
   output logic             sof,
   output logic             eof,
   output logic             src
);
   // state | meaning
   // IDLE  | no frame in flight; grants decoded here
   // SHIFT | serialising the captured word, DIV clocks per bit
   // GAP   | single dead cycle after the last bit, busy still high

   localparam int CNT_W = $clog2(WIDTH);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] grant_data;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_inc;
   logic [DIV_W-1:0] div_cnt;
   logic             rr_ptr;
   logic             grant, grant_idx;
   logic             div_done, last_bit;

   // Grants are masked during reset so a pending requester waits for a clean IDLE.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE && !reset) begin
         gnt0 = req0 && (!req1 || !rr_ptr);
         gnt1 = req1 && (!req0 || rr_ptr);
      end
   end

   assign grant       = gnt0 | gnt1;
   assign grant_idx   = gnt1;
   assign grant_data  = gnt1 ? data1 : data0;
   assign div_done    = (div_cnt == LAST_DIV);
   assign last_bit    = (bit_cnt == LAST_BIT);
   assign bit_cnt_inc = bit_cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = SHIFT;
         SHIFT:   if (div_done && last_bit) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // shreg holds only the bits not yet presented on so; bit 0 is always the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         div_cnt  <= '0;
         rr_ptr   <= 1'b0;
         busy     <= 1'b0;
         so       <= 1'b0;
         so_valid <= 1'b0;
         sof      <= 1'b0;
         eof      <= 1'b0;
         src      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  shreg    <= grant_data >> 1;
                  src      <= grant_idx;
                  so       <= grant_data[0];
                  so_valid <= 1'b1;
                  sof      <= 1'b1;
                  eof      <= 1'b0;
                  bit_cnt  <= '0;
                  div_cnt  <= '0;
                  rr_ptr   <= ~grant_idx;
                  busy     <= 1'b1;
               end
            end
            SHIFT: begin
               if (!div_done) begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end else if (!last_bit) begin
                  shreg   <= shreg >> 1;
                  so      <= shreg[0];
                  bit_cnt <= bit_cnt_inc;
                  div_cnt <= '0;
                  sof     <= 1'b0;
                  eof     <= (bit_cnt_inc == LAST_BIT);
               end else begin
                  so       <= 1'b0;
                  so_valid <= 1'b0;
                  sof      <= 1'b0;
                  eof      <= 1'b0;
               end
            end
            GAP: busy <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_piso_tx_sched.sv
// Scoreboard bench for piso_tx_sched: one instance at DIV=1, one at DIV=3, WIDTH=4.
// Stimulus pushes expected grants and per-cycle frame bits; a negedge monitor pops and compares.
module tb_piso_tx_sched;
   localparam int W = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic req0_a, req1_a, gnt0_a, gnt1_a, busy_a, so_a, so_valid_a, sof_a, eof_a, src_a;
   logic [W-1:0] data0_a, data1_a;
   logic req0_b, req1_b, gnt0_b, gnt1_b, busy_b, so_b, so_valid_b, sof_b, eof_b, src_b;
   logic [W-1:0] data0_b, data1_b;

   piso_tx_sched #(.WIDTH(W), .DIV(1)) dut_a (
      .clk(clk), .reset(reset),
      .req0(req0_a), .data0(data0_a), .gnt0(gnt0_a),
      .req1(req1_a), .data1(data1_a), .gnt1(gnt1_a),
      .busy(busy_a), .so(so_a), .so_valid(so_valid_a),
      .sof(sof_a), .eof(eof_a), .src(src_a)
   );

   piso_tx_sched #(.WIDTH(W), .DIV(3)) dut_b (
      .clk(clk), .reset(reset),
      .req0(req0_b), .data0(data0_b), .gnt0(gnt0_b),
      .req1(req1_b), .data1(data1_b), .gnt1(gnt1_b),
      .busy(busy_b), .so(so_b), .so_valid(so_valid_b),
      .sof(sof_b), .eof(eof_b), .src(src_b)
   );

   typedef struct packed {
      logic so;
      logic sof;
      logic eof;
      logic src;
      logic last;
   } bit_exp_t;

   bit_exp_t qa[$];
   bit_exp_t qb[$];
   logic     ga[$];
   logic     gb[$];
   bit       in_fr[2];
   int       n_chk = 0;
   int       n_fail = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int i, input logic s, input logic [W-1:0] d, input int div);
      bit_exp_t e;
      for (int b = 0; b < W; b++) begin
         for (int c = 0; c < div; c++) begin
            e.so   = d[b];
            e.sof  = (b == 0);
            e.eof  = (b == W - 1);
            e.src  = s;
            e.last = (b == W - 1) && (c == div - 1);
            if (i == 0) qa.push_back(e);
            else        qb.push_back(e);
         end
      end
   endtask

   task automatic mon(input int i, input logic g0, input logic g1, input logic sv,
                      input logic so_, input logic sof_, input logic eof_, input logic src_);
      bit_exp_t e;
      logic     eg;
      bit       have;
      if (reset) begin
         in_fr[i] = 1'b0;
         return;
      end
      if (g0 || g1) begin
         check("gnt_onehot", 16'(g0 & g1), 16'(0));
         have = (i == 0) ? (ga.size() > 0) : (gb.size() > 0);
         if (!have) begin
            check("gnt_unexpected", 16'(1), 16'(0));
         end else begin
            if (i == 0) eg = ga.pop_front();
            else        eg = gb.pop_front();
            check("gnt_index", 16'(g1), 16'(eg));
         end
      end
      if (sv) begin
         have = (i == 0) ? (qa.size() > 0) : (qb.size() > 0);
         if (!have) begin
            check("bit_unexpected", 16'(1), 16'(0));
         end else begin
            if (i == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            check("frame_bit{so,sof,eof,src}", 16'({so_, sof_, eof_, src_}),
                  16'({e.so, e.sof, e.eof, e.src}));
            in_fr[i] = !e.last;
         end
      end else begin
         check("so_idle_zero", 16'(so_), 16'(0));
         if (in_fr[i]) begin
            check("frame_gap", 16'(0), 16'(1));
            in_fr[i] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, gnt0_a, gnt1_a, so_valid_a, so_a, sof_a, eof_a, src_a);
      mon(1, gnt0_b, gnt1_b, so_valid_b, so_b, sof_b, eof_b, src_b);
   end

   task automatic wait_idle(input int i);
      int n = 0;
      while (n < 200 && ((i == 0) ? (busy_a | so_valid_a) : (busy_b | so_valid_b))) begin
         step();
         n++;
      end
      check("idle_timeout", 16'(n < 200), 16'(1));
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cnt;
      req0_a = 1'b0; req1_a = 1'b0; data0_a = '0; data1_a = '0;
      req0_b = 1'b0; req1_b = 1'b0; data0_b = '0; data1_b = '0;
      reset  = 1'b1;
      repeat (3) step();
      check("rst_out_a", 16'({busy_a, so_a, so_valid_a, sof_a, eof_a, src_a, gnt0_a, gnt1_a}), 16'(0));
      check("rst_out_b", 16'({busy_b, so_b, so_valid_b, sof_b, eof_b, src_b, gnt0_b, gnt1_b}), 16'(0));
      reset = 1'b0;
      step();

      // single word, DIV=1: 4'b1011 -> so 1,1,0,1
      req0_a = 1'b1; data0_a = 4'b1011;
      ga.push_back(1'b0);
      push_frame(0, 1'b0, 4'b1011, 1);
      #1 check("single_gnt0", 16'(gnt0_a), 16'(1));
      step();
      req0_a = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("single_valid", 16'(so_valid_a), 16'(1));
         step();
      end
      check("single_gap_valid", 16'(so_valid_a), 16'(0));
      check("single_gap_busy", 16'(busy_a), 16'(1));
      // back-to-back from a single continuous requester
      req0_a = 1'b1; data0_a = 4'b1110;
      ga.push_back(1'b0); ga.push_back(1'b0);
      push_frame(0, 1'b0, 4'b1110, 1);
      push_frame(0, 1'b0, 4'b1110, 1);
      #1 check("gap_no_gnt", 16'(gnt0_a), 16'(0));
      step();
      check("t6_busy_low", 16'(busy_a), 16'(0));
      check("t6_gnt0", 16'(gnt0_a), 16'(1));
      step();
      n = 1;
      while (!gnt0_a && n < 20) begin
         step();
         n++;
      end
      check("b2b_period", 16'(n), 16'(6));
      step();
      req0_a = 1'b0;
      wait_idle(0);

      // contention held from reset: grants 0,1,0,1
      reset = 1'b1;
      req0_a = 1'b1; data0_a = 4'b1001;
      req1_a = 1'b1; data1_a = 4'b0100;
      step();
      step();
      ga.push_back(1'b0); ga.push_back(1'b1); ga.push_back(1'b0); ga.push_back(1'b1);
      push_frame(0, 1'b0, 4'b1001, 1);
      push_frame(0, 1'b1, 4'b0100, 1);
      push_frame(0, 1'b0, 4'b1001, 1);
      push_frame(0, 1'b1, 4'b0100, 1);
      reset = 1'b0;
      #1;
      cnt = 0;
      n = 0;
      while (n < 100) begin
         if (gnt0_a | gnt1_a) cnt++;
         if (cnt == 4) break;
         step();
         n++;
      end
      check("contention_grants", 16'(cnt), 16'(4));
      step();
      req0_a = 1'b0; req1_a = 1'b0;
      wait_idle(0);

      // DIV=3, data1=0110 -> 000111111000; req0 pulse while busy is ignored
      req1_b = 1'b1; data1_b = 4'b0110;
      gb.push_back(1'b1);
      push_frame(1, 1'b1, 4'b0110, 3);
      #1 check("div3_gnt1", 16'(gnt1_b), 16'(1));
      step();
      req1_b = 1'b0;
      step();
      req0_b = 1'b1; data0_b = 4'b1111;
      #1 check("withdrawn_no_gnt0", 16'(gnt0_b), 16'(0));
      check("withdrawn_busy", 16'(busy_b), 16'(1));
      step();
      req0_b = 1'b0;
      wait_idle(1);

      // pointer: after requester 1 was served, requester 0 wins a tie
      req0_b = 1'b1; data0_b = 4'b1100;
      req1_b = 1'b1; data1_b = 4'b0011;
      gb.push_back(1'b0);
      push_frame(1, 1'b0, 4'b1100, 3);
      #1 check("ptr_gnt0", 16'(gnt0_b), 16'(1));
      check("ptr_no_gnt1", 16'(gnt1_b), 16'(0));
      step();
      req0_b = 1'b0; req1_b = 1'b0;
      wait_idle(1);

      // reset during bit 2 of 4'b0100 (bit 2 is the only 1)
      req1_b = 1'b1; data1_b = 4'b0100;
      gb.push_back(1'b1);
      push_frame(1, 1'b1, 4'b0100, 3);
      #1 check("midrst_gnt1", 16'(gnt1_b), 16'(1));
      repeat (8) step();
      check("pre_rst_so", 16'(so_b), 16'(1));
      #2 reset = 1'b1;
      #1 check("rst_async_out", 16'({so_b, so_valid_b, eof_b, sof_b, busy_b, src_b}), 16'(0));
      qb.delete();
      step();
      check("rst_gnt_gated", 16'(gnt1_b), 16'(0));
      gb.push_back(1'b1);
      push_frame(1, 1'b1, 4'b0100, 3);
      reset = 1'b0;
      #1 check("post_rst_gnt1", 16'(gnt1_b), 16'(1));
      step();
      req1_b = 1'b0;
      wait_idle(1);

      check("drain_bits_a", 16'(qa.size()), 16'(0));
      check("drain_bits_b", 16'(qb.size()), 16'(0));
      check("drain_gnts_a", 16'(ga.size()), 16'(0));
      check("drain_gnts_b", 16'(gb.size()), 16'(0));

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
